blackjack_round_ctrl: RTL
=========================

# blackjack_round_ctrl

Round sequencer for the two-player blackjack game. Owns both players' bank registers, the bet, and the card totals, and drives the 8-bit one-hot game `state`. In the result state it presents money, bet and totals to `result_calculator` and latches that block's new-money outputs back into the banks when the round closes. Cards come from an upstream card source over a req/valid handshake. Buttons arrive as debounced one-cycle pulses.

## Interface
- `INIT_MONEY`, default 8: bank value for both players after reset; legal range 1..15.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `btn_bet`  in  1  one-cycle pulse; adds 1 to the bet.
- `btn_hit`  in  1  one-cycle pulse; the active player draws a card.
- `btn_stand`  in  1  one-cycle pulse; the active player ends their turn.
- `btn_next`  in  1  one-cycle pulse; advances IDLE, BET and RESULT.
- `card_valid`  in  1  card handshake strobe; sampled only while `card_req` is high.
- `card_value`  in  4  card rank, 1..13.
- `player1_newmoney`, `player2_newmoney`  in  4 each  results from `result_calculator`.
- `state`  out  8  one-hot game state.
- `card_req`  out  1  high while a card is needed.
- `player1_card`, `player2_card`  out  6 each  running point totals.
- `player1_money`, `player2_money`  out  4 each  bank registers.
- `game_money`  out  4  current bet.
- `game_over`  out  1  high when either bank is 0.

## Operation
- **State encodings (one-hot):**
  - IDLE = 8'b00000001
  - BET = 8'b00000010
  - DEAL = 8'b00000100
  - P1_TURN = 8'b00001000
  - P1_DRAW = 8'b00010000
  - P2_TURN = 8'b00100000
  - P2_DRAW = 8'b01000000
  - RESULT = 8'b10000000
- **Reset values:** `state` = IDLE; banks = `INIT_MONEY`; `game_money` = 0; totals = 0; internal deal counter = 0.
- **Card scoring:** rank 1..9 scores its face value. Rank 10..15 scores 10. Rank 0 scores 1. Ace is always 1.
- **IDLE:** `btn_next` with `game_over` = 0 moves to BET and clears both totals. While `game_over` = 1, `btn_next` is ignored.
- **BET:**
  - max_bet = min(p1_money, p2_money, 15 − max(p1_money, p2_money)). This bound guarantees the calculator can neither underflow nor overflow a bank.
  - `btn_bet` increments `game_money`, saturating at max_bet.
  - `btn_next` with `game_money` ≥ 1 moves to DEAL; with `game_money` = 0 it is ignored.
- **DEAL:** accepts four cards in the order P1, P2, P1, P2, using a 2-bit counter. The fourth accepted card moves to P1_TURN.
- **P1_TURN:** `btn_stand` moves to P2_TURN. `btn_hit` moves to P1_DRAW. If both arrive in the same cycle, stand wins.
- **P1_DRAW:** the accepted card is added to `player1_card`. A new total above 21 moves to P2_TURN; otherwise the state returns to P1_TURN.
- **P2_TURN and P2_DRAW:** mirror the P1 states; stand or bust moves to RESULT. P2 plays even if P1 busted, because the calculator scores a double bust as a push.
- **RESULT:** inputs are held stable. `btn_next` latches `player1_newmoney` and `player2_newmoney` into the banks, clears `game_money`, and moves to IDLE.
- **Ignored inputs:** buttons with no meaning in the current state are ignored. `card_valid` is ignored while `card_req` = 0.
- **Width:** totals are 6-bit. The maximum reachable total is 31, so no wrap occurs.

## Timing
- Every output except `card_req` comes from a register. `card_req` is decoded from the state register: high in DEAL, P1_DRAW and P2_DRAW.
- A button pulse sampled at edge N produces the new `state` value after edge N, with no added latency.
- **Card handshake:** a card transfers on any edge where `card_req` and `card_valid` are both high.
  - The total and the state update on that same edge.
  - In DEAL, `card_valid` may be high on consecutive cycles; four back-to-back cards finish DEAL in 4 cycles.
- Bank latch in RESULT: the banks update on the `btn_next` edge, and `game_over` reflects the new values from the next cycle.
- Reset asserted mid-round: all registers return to their reset values asynchronously, and any card in flight is dropped.

## Structure
- **Shared package `blackjack_pkg`:**
  - the eight one-hot state constants;
  - `BUST_LIMIT` = 21;
  - money, card and total widths (4/4/6).
  - `result_calculator` imports the same RESULT constant.
- **Sub-module `card_scorer`:** combinational, maps the 4-bit rank to a 4-bit point value, one instance. The FSM, counters and bank registers stay in the top level.

## Test plan
- **Reset and bet limit:** reset with `INIT_MONEY` = 8, then `btn_next` and 9× `btn_bet` → `game_money` saturates at 7 and `state` = BET.
- **Back-to-back deal:** bet 3, then cards 5, 13, 1, 9 on consecutive cycles → `player1_card` = 6, `player2_card` = 19, P1_TURN after 4 cycles, `card_req` then drops.
- **P1 bust:** P1 at 6 hits 10, 10 → total 26, automatic move to P2_TURN; a further `btn_hit` does nothing until P2 acts.
- **Stand priority:** `btn_hit` and `btn_stand` in the same cycle in P2_TURN → RESULT, and no card is requested.
- **Bank latch and game over:** in RESULT with newmoney 0 and 15, `btn_next` → banks 0 and 15, IDLE, `game_over` = 1, and a further `btn_next` is ignored.
- **Reset mid-draw:** drop `rst_n` in P1_DRAW with `card_valid` high → IDLE, banks = 8, totals = 0, and the card is not added.

Source files
------------

// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared state encodings, limits and widths for the blackjack game
package blackjack_pkg;
  localparam int MONEY_W = 4;
  localparam int CARD_W = 4;
  localparam int TOTAL_W = 6;
  localparam int BUST_LIMIT = 21;
  typedef enum logic [7:0] {
    IDLE    = 8'b00000001,
    BET     = 8'b00000010,
    DEAL    = 8'b00000100,
    P1_TURN = 8'b00001000,
    P1_DRAW = 8'b00010000,
    P2_TURN = 8'b00100000,
    P2_DRAW = 8'b01000000,
    RESULT  = 8'b10000000
  } state_t;
endpackage

// File: rtl/blackjack_round_ctrl_if.sv
// blackjack_round_ctrl_if: buttons, card handshake, calculator results and game status
interface blackjack_round_ctrl_if;
  import blackjack_pkg::*;
  logic btn_bet, btn_hit, btn_stand, btn_next;
  logic card_valid, card_req;
  logic [CARD_W-1:0] card_value;
  logic [MONEY_W-1:0] player1_newmoney, player2_newmoney;
  logic [7:0] state;
  logic [TOTAL_W-1:0] player1_card, player2_card;
  logic [MONEY_W-1:0] player1_money, player2_money, game_money;
  logic game_over;
  modport master(
    output btn_bet, btn_hit, btn_stand, btn_next, card_valid, card_value,
           player1_newmoney, player2_newmoney,
    input  state, card_req, player1_card, player2_card, player1_money, player2_money,
           game_money, game_over
  );
  modport slave(
    input  btn_bet, btn_hit, btn_stand, btn_next, card_valid, card_value,
           player1_newmoney, player2_newmoney,
    output state, card_req, player1_card, player2_card, player1_money, player2_money,
           game_money, game_over
  );
endinterface

// File: rtl/card_scorer.sv
// card_scorer: maps a card rank to its point value; aces count 1, faces and out-of-range ranks 10
module card_scorer
  import blackjack_pkg::*;
(
  input  logic [CARD_W-1:0] rank,
  output logic [CARD_W-1:0] points
);
  always_comb points = (rank == '0) ? CARD_W'(1) : (rank >= CARD_W'(10)) ? CARD_W'(10) : rank;
endmodule

// File: rtl/blackjack_round_ctrl.sv
// blackjack_round_ctrl: round sequencer owning banks, bet and card totals for two players
module blackjack_round_ctrl
  import blackjack_pkg::*;
#(
  parameter int INIT_MONEY = 8
) (
  input logic clk,
  input logic rst_n,
  blackjack_round_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [1:0] deal_cnt;
  logic [CARD_W-1:0] pts;
  logic [TOTAL_W-1:0] p1_card, p2_card, p1_sum, p2_sum;
  logic [MONEY_W-1:0] p1_money, p2_money, game_money, hi, lo, room, max_bet;
  logic game_over, take;
  card_scorer u_scorer (.rank(bus.card_value), .points(pts));
  assign bus.card_req = state_q inside {DEAL, P1_DRAW, P2_DRAW};
  assign take = bus.card_req & bus.card_valid;
  assign p1_sum = p1_card + TOTAL_W'(pts);
  assign p2_sum = p2_card + TOTAL_W'(pts);
  // the bet may not exceed either bank nor push the richer bank past 15
  assign hi = (p1_money > p2_money) ? p1_money : p2_money;
  assign lo = (p1_money > p2_money) ? p2_money : p1_money;
  assign room = MONEY_W'(15) - hi;
  assign max_bet = (lo < room) ? lo : room;
  assign bus.state = state_q;
  assign bus.player1_card = p1_card;
  assign bus.player2_card = p2_card;
  assign bus.player1_money = p1_money;
  assign bus.player2_money = p2_money;
  assign bus.game_money = game_money;
  assign bus.game_over = game_over;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (bus.btn_next && !game_over) ? BET : IDLE;
      BET:     state_d = (bus.btn_next && game_money != '0) ? DEAL : BET;
      DEAL:    state_d = (take && deal_cnt == 2'd3) ? P1_TURN : DEAL;
      P1_TURN: state_d = bus.btn_stand ? P2_TURN : bus.btn_hit ? P1_DRAW : P1_TURN;
      P1_DRAW: state_d = !take ? P1_DRAW : (p1_sum > TOTAL_W'(BUST_LIMIT)) ? P2_TURN : P1_TURN;
      P2_TURN: state_d = bus.btn_stand ? RESULT : bus.btn_hit ? P2_DRAW : P2_TURN;
      P2_DRAW: state_d = !take ? P2_DRAW : (p2_sum > TOTAL_W'(BUST_LIMIT)) ? RESULT : P2_TURN;
      RESULT:  state_d = bus.btn_next ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p1_money <= MONEY_W'(INIT_MONEY);
      p2_money <= MONEY_W'(INIT_MONEY);
      game_money <= '0;
      game_over <= 1'b0;
      p1_card <= '0;
      p2_card <= '0;
      deal_cnt <= '0;
    end else begin
      if (state_q == IDLE && state_d == BET) begin
        p1_card <= '0;
        p2_card <= '0;
      end
      if (state_q == BET && bus.btn_bet && game_money < max_bet) game_money <= game_money + MONEY_W'(1);
      // deal alternates P1, P2, P1, P2 on the counter's low bit
      if (take && (state_q == P1_DRAW || (state_q == DEAL && !deal_cnt[0]))) p1_card <= p1_sum;
      if (take && (state_q == P2_DRAW || (state_q == DEAL && deal_cnt[0]))) p2_card <= p2_sum;
      if (take && state_q == DEAL) deal_cnt <= deal_cnt + 2'd1;
      if (state_q == RESULT && bus.btn_next) begin
        p1_money <= bus.player1_newmoney;
        p2_money <= bus.player2_newmoney;
        game_money <= '0;
        game_over <= (bus.player1_newmoney == '0) || (bus.player2_newmoney == '0);
      end
    end
endmodule
